// File: rtl/core_nios2_div_cell.sv
// Iterative radix-2 restoring divider for the A-stage execute path (signed/unsigned).
// Latency: start in cycle N -> A_div_done pulse with results in cycle N+WIDTH+2.
// Backpressure: none; A_div_busy is high N+1..N+WIDTH+1 and starts while busy are dropped.
//
// Ports:
//   clk, reset_n            core clock, asynchronous active-low reset
//   A_div_start             start strobe, honoured only while A_div_busy is low
//   A_div_signed            1 = two's-complement, 0 = unsigned (captured with start)
//   A_div_src1/A_div_src2   dividend / divisor (captured with start)
//   A_div_busy              operation in progress
//   A_div_done              one-cycle pulse, A_div_quot/A_div_rem valid
//   A_div_quot/A_div_rem    quotient (toward zero) / remainder (sign of dividend)
module core_nios2_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             A_div_start,
  input  logic             A_div_signed,
  input  logic [WIDTH-1:0] A_div_src1,
  input  logic [WIDTH-1:0] A_div_src2,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_quot,
  output logic [WIDTH-1:0] A_div_rem
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] op1;       // raw dividend, kept for the divide-by-zero result
  logic [WIDTH-1:0] op2;
  logic             sgn_mode;
  logic             div_zero;
  logic             quot_neg;
  logic             rem_neg;
  logic [WIDTH-1:0] rem_acc;   // partial remainder
  logic [WIDTH-1:0] dvd;       // dividend magnitude, quotient bits shift in from the bottom
  logic [WIDTH-1:0] dvs_mag;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_step;
  logic             neg1;
  logic             neg2;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quot_step;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // The done cycle is not busy, so a new start is taken in FIX as well as IDLE.
  assign accept    = A_div_start && (state == IDLE || state == FIX);
  assign last_step = (state == ITER) && (cnt == '0);

  assign A_div_busy = (state == PREP) || (state == ITER);
  assign A_div_done = (state == FIX);

  // Magnitude of MIN negates to itself, which reads correctly as 2^(WIDTH-1) unsigned.
  assign neg1 = sgn_mode && op1[WIDTH-1];
  assign neg2 = sgn_mode && op2[WIDTH-1];

  // One restoring step: the WIDTH+1-bit trial subtract's top bit is the borrow.
  assign shifted   = {rem_acc, dvd[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvs_mag};
  assign q_bit     = ~trial[WIDTH];
  assign rem_step  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_step = {dvd[WIDTH-2:0], q_bit};

  assign quot_fix = quot_neg ? (~quot_step + 1'b1) : quot_step;
  assign rem_fix  = rem_neg  ? (~rem_step  + 1'b1) : rem_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (A_div_start) state_nxt = PREP;
      PREP:    state_nxt = ITER;
      ITER:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = A_div_start ? PREP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op1        <= '0;
      op2        <= '0;
      sgn_mode   <= 1'b0;
      div_zero   <= 1'b0;
      quot_neg   <= 1'b0;
      rem_neg    <= 1'b0;
      rem_acc    <= '0;
      dvd        <= '0;
      dvs_mag    <= '0;
      cnt        <= '0;
      A_div_quot <= '0;
      A_div_rem  <= '0;
    end else begin
      if (accept) begin
        op1      <= A_div_src1;
        op2      <= A_div_src2;
        sgn_mode <= A_div_signed;
        div_zero <= (A_div_src2 == '0);
      end

      if (state == PREP) begin
        dvd      <= neg1 ? (~op1 + 1'b1) : op1;
        dvs_mag  <= neg2 ? (~op2 + 1'b1) : op2;
        quot_neg <= neg1 ^ neg2;
        rem_neg  <= neg1;
        rem_acc  <= '0;
        cnt      <= CW'(WIDTH - 1);
      end

      if (state == ITER) begin
        rem_acc <= rem_step;
        dvd     <= quot_step;
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end
      end

      // Sign fix-up is applied on the edge into FIX so the results are already
      // on the outputs during the done cycle.
      if (last_step) begin
        A_div_quot <= div_zero ? '1  : quot_fix;
        A_div_rem  <= div_zero ? op1 : rem_fix;
      end
    end
  end

endmodule

// File: tb/tb_core_nios2_div_cell.sv
// Self-checking bench for core_nios2_div_cell at WIDTH=32.
// Directed and random operations are compared against an arithmetic reference model.
// Cycle-accurate busy/done profile and output hold behaviour are checked on every operation.
module tb_core_nios2_div_cell;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         A_div_start;
  logic         A_div_signed;
  logic [W-1:0] A_div_src1;
  logic [W-1:0] A_div_src2;
  logic         A_div_busy;
  logic         A_div_done;
  logic [W-1:0] A_div_quot;
  logic [W-1:0] A_div_rem;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  core_nios2_div_cell #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .A_div_start  (A_div_start),
    .A_div_signed (A_div_signed),
    .A_div_src1   (A_div_src1),
    .A_div_src2   (A_div_src2),
    .A_div_busy   (A_div_busy),
    .A_div_done   (A_div_done),
    .A_div_quot   (A_div_quot),
    .A_div_rem    (A_div_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer division with the two special cases stated explicitly.
  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Called at a negedge (cycle N). Returns at the negedge of the done cycle N+34,
  // so an immediately following call starts in the done cycle.
  // poke: scramble operands while busy and fire an extra start (9/3) at N+5.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    model(s, a, b, eq, er);
    A_div_start  = 1'b1;
    A_div_signed = s;
    A_div_src1   = a;
    A_div_src2   = b;
    @(negedge clk);
    A_div_start = 1'b0;
    for (int i = 1; i <= W + 2; i++) begin
      if (i > 1) @(negedge clk);
      chk("busy", {31'b0, A_div_busy}, {31'b0, (i <= W + 1)});
      chk("done", {31'b0, A_div_done}, {31'b0, (i == W + 2)});
      if (i == 1 || i == W + 1) begin
        chk("hold_quot", A_div_quot, last_q);
        chk("hold_rem", A_div_rem, last_r);
      end
      if (i == W + 2) begin
        chk("quot", A_div_quot, eq);
        chk("rem", A_div_rem, er);
      end
      if (poke && i < W + 2) begin
        A_div_signed = 1'($urandom_range(0, 1));
        A_div_src1   = $urandom;
        A_div_src2   = $urandom;
        A_div_start  = (i == 5);
        if (i == 5) begin
          A_div_signed = 1'b0;
          A_div_src1   = 32'd9;
          A_div_src2   = 32'd3;
        end
      end
    end
    A_div_start = 1'b0;
    last_q = eq;
    last_r = er;
  endtask

  logic [W-1:0] ra;
  logic [W-1:0] rb;
  bit           saw_done;

  initial begin
    reset_n      = 1'b0;
    A_div_start  = 1'b0;
    A_div_signed = 1'b0;
    A_div_src1   = '0;
    A_div_src2   = '0;
    last_q       = '0;
    last_r       = '0;

    #1;
    chk("rst_busy", {31'b0, A_div_busy}, '0);
    chk("rst_done", {31'b0, A_div_done}, '0);
    chk("rst_quot", A_div_quot, '0);
    chk("rst_rem", A_div_rem, '0);

    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Unsigned 100/7 with an ignored start at N+5, then 9/3 issued in the done cycle.
    run_op(1'b0, 32'd100, 32'd7, 1'b1);
    run_op(1'b0, 32'd9, 32'd3, 1'b0);
    repeat (2) @(negedge clk);

    // Signed cases, with operands scrambled while busy.
    run_op(1'b1, 32'hFFFF_FFF9, 32'h2, 1'b1);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
    @(negedge clk);

    // Divide-by-zero, overflow, extremes.
    run_op(1'b0, 32'h1234_5678, 32'h0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFB, 32'h0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'h1, 1'b0);
    @(negedge clk);

    // Reset mid-ITER aborts the operation.
    A_div_start  = 1'b1;
    A_div_signed = 1'b0;
    A_div_src1   = 32'd100;
    A_div_src2   = 32'd7;
    @(negedge clk);
    A_div_start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, A_div_busy}, '0);
    chk("abort_done", {31'b0, A_div_done}, '0);
    chk("abort_quot", A_div_quot, '0);
    chk("abort_rem", A_div_rem, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (A_div_done) saw_done = 1'b1;
    end
    chk("no_done_after_abort", {31'b0, saw_done}, '0);
    last_q = '0;
    last_r = '0;
    run_op(1'b0, 32'd50, 32'd5, 1'b0);

    // Random operations, mixing corner operands, back-to-back and idle gaps.
    for (int k = 0; k < 30; k++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: rb = 32'($urandom_range(1, 300));
        2: rb = '0;
        3: ra = 32'h8000_0000;
        4: rb = 32'hFFFF_FFFF;
        default: begin
          ra = 32'($signed(12'($urandom)));
          rb = 32'($signed(5'($urandom)));
        end
      endcase
      run_op(1'($urandom_range(0, 1)), ra, rb, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
